// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM encoding, legal oversampling ratios, line levels
// and the parity/prescale helpers used by the transmit path.
package uart_tx_frame_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity is the plain XOR; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic presc_legal(input logic [5:0] presc);
    return (presc == PRESC_8) || (presc == PRESC_16) || (presc == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts oversampled clocks 0..Prescale-1 and strobes bit_done
// on the last clock of each bit.
module uart_tx_bit_timer
  import uart_tx_frame_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_clear,
  input  logic [5:0] i_prescale,
  output logic       o_bit_done
);

  logic [4:0] r_cnt;
  logic [5:0] w_last;

  // Compare at 6 bits so Prescale=32 (last count 31) needs no special case.
  assign w_last     = i_prescale - 6'd1;
  assign o_bit_done = ({1'b0, r_cnt} == w_last) && !i_clear;

  // Edge counter, held at zero while cleared and wrapped at the end of each bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= 5'd0;
    end else if (i_clear || o_bit_done) begin
      r_cnt <= 5'd0;
    end else begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit, each
// held for Prescale clocks; back-to-back frames chain without an idle cycle.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [5:0]            r_presc;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_tx_nxt;
  logic                  w_req_ok;
  logic                  w_accept;
  logic                  w_bit_done;
  logic                  w_clear;

  assign w_req_ok = Data_Valid && presc_legal(Prescale);
  assign w_clear  = (r_state == IDLE);
  assign TX_OUT   = r_tx;
  assign Busy     = r_busy;

  uart_tx_bit_timer u_bit_timer (
    .CLK        (CLK),
    .RST        (RST),
    .i_clear    (w_clear),
    .i_prescale (r_presc),
    .o_bit_done (w_bit_done)
  );

  // Next-state, bit index and accept decision.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_bit_done && (r_idx == 3'd7)) begin
          w_idx_nxt   = 3'd0;
          w_state_nxt = r_par_en ? PARITY : STOP;
        end else if (w_bit_done) begin
          w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_state_nxt = DATA;
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
        end else begin
          w_state_nxt = PARITY;
        end
      end
      STOP: begin
        if (w_bit_done && w_req_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
        end else if (w_bit_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Line level for the cycle after the edge, so TX_OUT can be registered.
  always_comb begin
    w_tx_nxt = STOP_BIT;
    case (w_state_nxt)
      IDLE:    w_tx_nxt = STOP_BIT;
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = r_data[w_idx_nxt];
      PARITY:  w_tx_nxt = parity_bit(r_data, r_par_typ);
      STOP:    w_tx_nxt = STOP_BIT;
      default: w_tx_nxt = STOP_BIT;
    endcase
  end

  // State, index and registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_tx    <= STOP_BIT;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Frame parameters are frozen at accept and ignored for the rest of the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_presc   <= 6'd0;
    end else if (w_accept) begin
      r_data    <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
      r_presc   <= Prescale;
    end else begin
      r_data    <= r_data;
      r_par_en  <= r_par_en;
      r_par_typ <= r_par_typ;
      r_presc   <= r_presc;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a reference model queues the expected line
// slots of every accepted frame; a monitor checks the serial line against them.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       TX_OUT;
  logic       Busy;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int start;
    int len;
    bit val;
    int frame;
    int slot;
  } slot_t;

  slot_t q[$];
  int    cyc = 0;
  int    free_at = 0;
  int    frames = 0;
  int    checks = 0;
  int    errors = 0;
  bit    flush_req = 1'b0;
  int    idle_cnt = 0;
  int    idle_bad = 0;

  function automatic bit legal(input int p);
    return (p == 8) || (p == 16) || (p == 32);
  endfunction

  // Expected line for one frame accepted at posedge n: one queue entry per bit slot.
  task automatic push_frame(input int n, input logic [7:0] d, input bit pen, input bit ptyp, input int p);
    slot_t s;
    int    ones;
    ones    = 0;
    s.frame = frames;
    s.len   = p;
    s.start = n; s.val = 1'b0; s.slot = 0;
    q.push_back(s);
    for (int i = 0; i < 8; i++) begin
      s.start = n + p * (1 + i);
      s.val   = d[i];
      s.slot  = 1 + i;
      ones    = ones + int'(d[i]);
      q.push_back(s);
    end
    if (pen) begin
      s.start = n + 9 * p;
      s.val   = ((ones % 2) == 1) ^ ptyp;
      s.slot  = 9;
      q.push_back(s);
    end
    s.start = n + p * (pen ? 10 : 9);
    s.val   = 1'b1;
    s.slot  = 10;
    q.push_back(s);
    free_at = n + p * (pen ? 11 : 10);
    frames  = frames + 1;
  endtask

  // Reference model: decides acceptance from the rules, independent of the DUT.
  initial begin
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
      if (RST && Data_Valid && legal(int'(Prescale)) && (cyc >= free_at))
        push_frame(cyc, P_DATA, PAR_EN, PAR_TYP, int'(Prescale));
    end
  end

  // Monitor: one comparison per bit slot and per idle stretch.
  initial begin
    int bit_bad;
    logic last_tx;
    logic last_busy;
    bit_bad = 0;
    last_tx = 1'b0;
    last_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (flush_req) begin
        bit_bad   = 0;
        flush_req = 1'b0;
      end
      if ((q.size() > 0) && (cyc >= q[0].start)) begin
        if (idle_cnt > 0) begin
          checks = checks + 1;
          if (idle_bad != 0) begin
            errors = errors + 1;
            $display("FAIL idle_line: %0d of %0d cycles wrong, last got tx=%b busy=%b, required tx=1 busy=0",
                     idle_bad, idle_cnt, last_tx, last_busy);
          end
          idle_cnt = 0;
          idle_bad = 0;
        end
        if ((TX_OUT !== q[0].val) || (Busy !== 1'b1)) begin
          bit_bad   = bit_bad + 1;
          last_tx   = TX_OUT;
          last_busy = Busy;
        end
        if (cyc >= q[0].start + q[0].len - 1) begin
          checks = checks + 1;
          if (bit_bad != 0) begin
            errors = errors + 1;
            $display("FAIL frame_bit frame=%0d slot=%0d: %0d of %0d cycles wrong, got tx=%b busy=%b, required tx=%b busy=1",
                     q[0].frame, q[0].slot, bit_bad, q[0].len, last_tx, last_busy, q[0].val);
          end
          void'(q.pop_front());
          bit_bad = 0;
        end
      end else begin
        idle_cnt = idle_cnt + 1;
        if ((TX_OUT !== 1'b1) || (Busy !== 1'b0)) begin
          idle_bad  = idle_bad + 1;
          last_tx   = TX_OUT;
          last_busy = Busy;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit pen, input bit ptyp, input logic [5:0] p);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = p; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_idle: %0d slots still pending after %0d cycles, required 0", q.size(), limit);
      q.delete();
      flush_req = 1'b1;
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_frames(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (frames >= target) break;
      @(negedge CLK);
    end
    if (frames < target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_frames: %0d frames accepted, required %0d", frames, target);
    end
  endtask

  task automatic check_reset_lines(input string name);
    checks = checks + 1;
    if ((TX_OUT !== 1'b1) || (Busy !== 1'b0)) begin
      errors = errors + 1;
      $display("FAIL %s: got tx=%b busy=%b, required tx=1 busy=0", name, TX_OUT, Busy);
    end
  endtask

  initial begin
    #2000000;
    errors = errors + 1;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n0;
    int pick;
    logic [5:0] presc_tab [4];
    presc_tab[0] = 6'd8; presc_tab[1] = 6'd16; presc_tab[2] = 6'd32; presc_tab[3] = 6'd12;

    #22;
    check_reset_lines("reset_state");
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;

    // Basic frame, even parity, and odd parity / no parity at Prescale 16.
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    wait_idle(200);
    send(8'h01, 1'b1, 1'b1, 6'd16);
    wait_idle(400);
    send(8'hFF, 1'b0, 1'b0, 6'd16);
    wait_idle(400);

    // Back-to-back at Prescale 32 with Data_Valid held high.
    n0 = frames;
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd32; Data_Valid = 1'b1;
    wait_frames(n0 + 1, 10);
    @(negedge CLK);
    P_DATA = 8'hC3;
    wait_frames(n0 + 2, 500);
    @(negedge CLK);
    Data_Valid = 1'b0;
    wait_idle(800);

    // Requests and input changes during a frame are ignored.
    send(8'h5A, 1'b1, 1'b0, 6'd8);
    repeat (20) @(negedge CLK);
    P_DATA = 8'hFF; Prescale = 6'd16; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    P_DATA = 8'h00; Prescale = 6'd32; PAR_TYP = 1'b1;
    wait_idle(200);

    // Illegal prescale is never accepted.
    send(8'h55, 1'b1, 1'b0, 6'd12);
    repeat (40) @(negedge CLK);

    // Reset in the middle of the data bits, then a clean frame.
    send(8'h96, 1'b1, 1'b1, 6'd8);
    repeat (30) @(negedge CLK);
    #2 RST = 1'b0;
    q.delete();
    flush_req = 1'b1;
    free_at = 0;
    #1 check_reset_lines("reset_mid_frame");
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    send(8'hC5, 1'b0, 1'b0, 6'd8);
    wait_idle(200);

    // Randomised frames, including occasional illegal prescale.
    for (int k = 0; k < 10; k++) begin
      pick = int'($urandom_range(0, 3));
      send(8'($urandom), 1'($urandom), 1'($urandom), presc_tab[pick]);
      wait_idle(11 * 32 + 20);
    end

    repeat (5) @(negedge CLK);
    if (idle_cnt > 0) begin
      checks = checks + 1;
      if (idle_bad != 0) begin
        errors = errors + 1;
        $display("FAIL idle_line_final: %0d of %0d cycles wrong, required tx=1 busy=0", idle_bad, idle_cnt);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
